// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Optional feature macro used by this block: REGFILE_MP_BYPASS_EN.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Address width needed to index n registers (n is a power of two, >= 2).
    function automatic int calc_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register, set on issue,
// cleared on write-back, with issue winning a same-cycle collision.
// With REGFILE_MP_BYPASS_EN defined, a same-cycle write-back hides the
// busy flag of the register being read.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = calc_aw(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_rd_i,
    output logic [NRD-1:0]    rd_busy_o,
    output logic              stall_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy state: write-backs clear first, then an issue sets (issue wins).
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0)) begin
                busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en_i && (iss_rd_i != '0)) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy array state; reset clears every flag immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per-port busy lookup; register 0 is never busy.
    always_comb begin
        rd_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]] && (rd_addr_i[k*AW +: AW] != '0);
`ifdef REGFILE_MP_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i[k*AW +: AW]) &&
                    !(iss_en_i && (iss_rd_i == rd_addr_i[k*AW +: AW]))) begin
                    rd_busy_o[k] = 1'b0;
                end
            end
`endif
        end
    end

    // Stall on any busy operand or on re-issuing a still-pending destination.
    always_comb begin
        stall_o = (|rd_busy_o) || (iss_en_i && busy_q[iss_rd_i]);
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero register 0 and an issue
// scoreboard. Write port 1 wins over port 0 on an address collision.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = calc_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    output logic                stall
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    // Next storage state; later write ports override earlier ones, x0 stays zero.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                mem_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
        mem_d[0] = '0;
    end

    // Storage array; reset clears every register immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational read ports, optionally forwarding same-cycle write data.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rd_addr[k*AW +: AW] != '0) begin
                rd_data[k*XLEN +: XLEN] = mem_q[rd_addr[k*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (!rst && wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW])) begin
                        rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                    end
                end
`endif
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i     (clk),
        .rst_i     (rst),
        .rd_addr_i (rd_addr),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .iss_en_i  (iss_en),
        .iss_rd_i  (iss_rd),
        .rd_busy_o (rd_busy),
        .stall_o   (stall)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (XLEN=32, NREGS=32, NRD=2, NWR=2).
// Expected values follow REGFILE_MP_BYPASS_EN when it is defined.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        stall;

    int checks = 0;
    int errors = 0;

    regfile_mp #(
        .XLEN  (32),
        .NREGS (32),
        .NRD   (2),
        .NWR   (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .iss_en  (iss_en),
        .iss_rd  (iss_rd),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        iss_en  = 1'b0;
        iss_rd  = '0;

        // Reset state
        #3;
        check("reset_rd_data", rd_data, 64'h0);
        check("reset_rd_busy", rd_busy, 2'b00);
        check("reset_stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Collision: port 0 writes 0x11, port 1 writes 0x22 to reg 5
        @(negedge clk);
        wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'h22, 32'h11};
        @(negedge clk);
        wr_en = 2'b00; rd_addr = {5'd0, 5'd5};
        #1;
        check("collision_reg5", rd_data[31:0], 32'h22);

        // Write to x0 is ignored
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hDEADBEEF};
        @(negedge clk);
        wr_en = 2'b00; rd_addr = {5'd0, 5'd0};
        #1;
        check("x0_reads_zero", rd_data[31:0], 32'h0);

        // Independent writes on both ports, read on both ports
        @(negedge clk);
        wr_en = 2'b11; wr_addr = {5'd6, 5'd4}; wr_data = {32'h66, 32'h44};
        @(negedge clk);
        wr_en = 2'b00; rd_addr = {5'd6, 5'd4};
        #1;
        check("dual_write_reg4", rd_data[31:0], 32'h44);
        check("dual_write_reg6", rd_data[63:32], 32'h66);

        // Issue reg 7: not yet busy during the issuing cycle
        @(negedge clk);
        iss_en = 1'b1; iss_rd = 5'd7;
        #1;
        check("issue_first_stall", stall, 1'b0);
        // Re-issue of pending reg 7 stalls with no busy operand
        @(negedge clk);
        #1;
        check("reissue_rd_busy", rd_busy, 2'b00);
        check("reissue_stall", stall, 1'b1);
        @(negedge clk);
        iss_en = 1'b0; rd_addr = {5'd6, 5'd7};
        #1;
        check("busy_reg7_rd_busy", rd_busy, 2'b01);
        check("busy_reg7_stall", stall, 1'b1);

        // Write-back reg 7 = 5 on port 1 while reading it
        @(negedge clk);
        wr_en = 2'b10; wr_addr = {5'd7, 5'd0}; wr_data = {32'h5, 32'h0};
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        check("wb7_same_cycle_busy", rd_busy, 2'b00);
        check("wb7_same_cycle_data", rd_data[31:0], 32'h5);
`else
        check("wb7_same_cycle_busy", rd_busy, 2'b01);
        check("wb7_same_cycle_data", rd_data[31:0], 32'h0);
`endif
        @(negedge clk);
        wr_en = 2'b00;
        #1;
        check("wb7_next_busy", rd_busy, 2'b00);
        check("wb7_next_data", rd_data[31:0], 32'h5);
        check("wb7_next_stall", stall, 1'b0);

        // Issue to x0 never marks it busy
        @(negedge clk);
        iss_en = 1'b1; iss_rd = 5'd0;
        @(negedge clk);
        iss_en = 1'b0; rd_addr = {5'd0, 5'd0};
        #1;
        check("x0_never_busy", rd_busy, 2'b00);

        // Same-cycle issue and write-back of reg 9: issue wins
        @(negedge clk);
        iss_en = 1'b1; iss_rd = 5'd9;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
        @(negedge clk);
        iss_en = 1'b0; wr_en = 2'b00; rd_addr = {5'd0, 5'd9};
        #1;
        check("iss_wb9_busy", rd_busy, 2'b01);
        check("iss_wb9_data", rd_data[31:0], 32'h99);
        check("iss_wb9_stall", stall, 1'b1);

        // Same-cycle write/read of reg 3 (bypass behaviour)
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h33};
        @(negedge clk);
        wr_data = {32'h0, 32'hA5A5A5A5}; rd_addr = {5'd0, 5'd3};
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        check("byp3_same_cycle", rd_data[31:0], 32'hA5A5A5A5);
`else
        check("byp3_same_cycle", rd_data[31:0], 32'h33);
`endif
        @(negedge clk);
        wr_en = 2'b00;
        #1;
        check("byp3_next_cycle", rd_data[31:0], 32'hA5A5A5A5);

        // Asynchronous reset mid-run with a write pending
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'hBAD};
        iss_en = 1'b1; iss_rd = 5'd9; rd_addr = {5'd9, 5'd3};
        #1;
        rst = 1'b1;
        #1;
        check("midrst_rd_data", rd_data, 64'h0);
        check("midrst_rd_busy", rd_busy, 2'b00);
        check("midrst_stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0; wr_en = 2'b00; iss_en = 1'b0; rd_addr = {5'd9, 5'd4};
        #1;
        check("post_rst_reg4", rd_data[31:0], 32'h0);
        check("post_rst_reg9", rd_data[63:32], 32'h0);
        check("post_rst_busy", rd_busy, 2'b00);

        // First write after reset release is accepted
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h1234};
        @(negedge clk);
        wr_en = 2'b00;
        #1;
        check("first_write_after_rst", rd_data[31:0], 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, meaning number of write ports (1..2).
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 rd_addr  in  NRD*AW  read addresses, port k in bits [k*AW +: AW].
REQ-008 rd_data  out  NRD*XLEN  read data per port.
REQ-009 rd_busy  out  NRD  per-port scoreboard busy flag of the addressed register.
REQ-010 wr_en  in  NWR  write enables.
REQ-011 wr_addr  in  NWR*AW  write addresses.
REQ-012 wr_data  in  NWR*XLEN  write data.
REQ-013 iss_en  in  1  issue strobe: mark iss_rd pending.
REQ-014 iss_rd  in  AW  destination register being issued.
REQ-015 stall  out  1  high when any rd_busy bit is high or iss_rd is busy while iss_en is high.

Function
REQ-016 Register 0 SHALL read as zero on every port, ignore writes, and never be marked busy.
REQ-017 Writes SHALL commit on the rising clk edge when wr_en[j] is high; visible on rd_data the following cycle (without bypass).
REQ-018 Two write ports targeting the same register in one cycle SHALL resolve with port 1 winning.
REQ-019 Reads SHALL be combinational from the storage array (zero-cycle read latency).
REQ-020 Scoreboard SHALL hold one busy bit per register; iss_en with iss_rd!=0 SETS bit iss_rd at the edge.
REQ-021 Any wr_en[j] to a nonzero register SHALL CLEAR its busy bit at the edge.
REQ-022 Issue and write-back to the same register in the same cycle SHALL leave the bit SET (issue wins).
REQ-023 rd_busy[k] SHALL reflect the current busy bit of rd_addr[k], forced low for address 0.
REQ-024 stall SHALL be purely combinational from rd_busy, iss_en, iss_rd and the busy array.
REQ-025 Out-of-range addresses cannot occur (AW exactly spans NREGS); no checking required.

Reset
REQ-026 Asserting rst SHALL immediately clear all registers to 0 and all busy bits to 0, independent of clk.
REQ-027 During reset rd_data SHALL be 0, rd_busy 0, stall 0; writes and issues are ignored.
REQ-028 Reset asserted mid-write SHALL discard the write; first write accepted on the first edge after rst deasserts.

Configuration
REQ-029 Macro REGFILE_MP_BYPASS_EN: when defined, rd_data[k] SHALL return wr_data of a same-cycle write to rd_addr[k] (port 1 priority, never for address 0) and rd_busy[k] SHALL read low for that register unless iss_en targets it.
REQ-030 Without REGFILE_MP_BYPASS_EN, rd_data and rd_busy SHALL reflect stored state only; same-cycle write data appears next cycle.

Structure
REQ-031 Shared package regfile_pkg SHALL hold default XLEN/NREGS constants and a function computing AW.
REQ-032 One sub-module regfile_scoreboard SHALL implement the busy array, set/clear priority and rd_busy/stall logic; storage and bypass stay in regfile_mp.

Verification
REQ-033 Reset: assert rst mid-run with registers written -> all rd_data read 0, stall 0 immediately.
REQ-034 Write x0: wr_en[0]=1, wr_addr=0, wr_data=32'hDEADBEEF -> next cycle read addr 0 returns 0.
REQ-035 Collision: both ports write reg 5 with 32'h11 / 32'h22 -> reg 5 reads 32'h22 next cycle.
REQ-036 Scoreboard: issue reg 7, read addr 7 -> rd_busy=1, stall=1; write reg 7 = 32'h5 -> next cycle busy 0, data 32'h5.
REQ-037 Same-cycle issue+writeback reg 9 -> busy bit remains 1 next cycle.
REQ-038 Bypass (macro on): write reg 3 = 32'hA5A5A5A5 while reading addr 3 -> rd_data=32'hA5A5A5A5 same cycle; macro off -> old value same cycle, new value next cycle.
